// File: rtl/load_store_unit_if.sv
// Request/response handshake plus data-memory port of the load/store unit.
// The slave side is the LSU itself; the master side is the requester together with its memory.
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata, mem_raddr
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata, mem_raddr
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: byte/half/word accesses to a word-wide memory,
// sub-word stores by read-modify-write, little-endian lanes, misalignment reported as error.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic clk,
    input logic rst,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, LD_ADDR, LD_DATA, RMW_ADDR, RMW_DATA, ST_WR, RESP
    } state_t;

    state_t state, state_next;

    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [1:0]            lane_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  accept;
    logic                  req_err;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] merged;

    assign accept = bus.req_valid && bus.req_ready;

    always_comb begin
        req_err = 1'b0;
        unique case (bus.req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = bus.req_addr[0];
            2'b10:   req_err = (bus.req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                  state_next = RESP;
                    else if (!bus.req_we)         state_next = LD_ADDR;
                    else if (bus.req_size == 2'b10) state_next = ST_WR;
                    else                          state_next = RMW_ADDR;
                end
            end
            LD_ADDR:  state_next = LD_DATA;
            LD_DATA:  state_next = RESP;
            RMW_ADDR: state_next = RMW_DATA;
            RMW_DATA: state_next = ST_WR;
            ST_WR:    state_next = RESP;
            RESP:     if (bus.resp_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Lane extraction and merge both work on the word returned for the registered address.
    always_comb begin
        byte_sel = bus.mem_rdata[{lane_q, 3'b000} +: 8];
        half_sel = bus.mem_rdata[{lane_q[1], 4'b0000} +: 16];
        load_ext = bus.mem_rdata;
        unique case (size_q)
            2'b00:   load_ext = uns_q ? {{(DATA_WIDTH-8){1'b0}}, byte_sel}
                                      : {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = uns_q ? {{(DATA_WIDTH-16){1'b0}}, half_sel}
                                      : {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            default: load_ext = bus.mem_rdata;
        endcase

        merged = bus.mem_rdata;
        if (size_q == 2'b00) merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else                 merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            lane_q  <= '0;
            err_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q    <= bus.req_we;
                size_q  <= bus.req_size;
                uns_q   <= bus.req_unsigned;
                lane_q  <= bus.req_addr[1:0];
                err_q   <= req_err;
                waddr_q <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                wdata_q <= bus.req_wdata;
            end
            if (state == LD_DATA)  rdata_q <= load_ext;
            if (state == RMW_DATA) wdata_q <= merged;
        end
    end

    assign bus.req_ready  = (state == IDLE) && !rst;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_err   = err_q;
    // rdata_q is only refreshed by loads, so stores and errors are masked here.
    assign bus.resp_rdata = (we_q || err_q) ? '0 : rdata_q;
    assign bus.mem_we     = (state == ST_WR);
    assign bus.mem_addr   = waddr_q;
    assign bus.mem_raddr  = waddr_q;
    assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed spec scenarios plus random traffic
// checked against a byte-addressed reference memory.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   wr_count = 0;

    always #5 clk = ~clk;

    load_store_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Word-wide memory seen by the DUT; reads return one cycle after the address.
    logic [31:0] tb_mem [int unsigned];
    always @(posedge clk) begin
        logic [31:0] rd;
        rd = tb_mem.exists(bus.mem_raddr) ? tb_mem[bus.mem_raddr] : 32'h0;
        if (bus.mem_we) begin
            tb_mem[bus.mem_addr] = bus.mem_wdata;
            wr_count++;
        end
        bus.mem_rdata <= rd;
    end

    // Reference model: plain byte array, little-endian assembly.
    logic [7:0] ref_mem [int unsigned];

    function automatic logic [7:0] ref_byte(input int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic bit ref_is_err(input logic [1:0] size, input int unsigned a);
        return (size == 2'd3) || (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0);
    endfunction

    function automatic void ref_store(input logic [1:0] size, input int unsigned a, input logic [31:0] d);
        logic [31:0] v;
        for (int unsigned i = 0; i < (1 << size); i++) begin
            v = d >> (8 * i);
            ref_mem[a + i] = v[7:0];
        end
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns, input int unsigned a);
        logic [31:0] v;
        int unsigned n;
        v = '0;
        n = 1 << size;
        for (int unsigned i = 0; i < n; i++) v = v | (32'(ref_byte(a + i)) << (8 * i));
        if (!uns && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // Drives one request and reports what was observed; callers do the checking.
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output int we_cnt, output logic [31:0] wr_addr,
                           output logic [31:0] wr_data, output logic [31:0] raddr,
                           output logic [31:0] rdata, output logic err,
                           output logic rdy_in_resp, output logic idle_after, output logic timed_out);
        int n;
        lat = 0; we_cnt = 0; wr_addr = '0; wr_data = '0; raddr = '0; rdata = '0;
        err = 1'b0; rdy_in_resp = 1'b0; idle_after = 1'b0; timed_out = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.req_ready) begin bus.req_valid = 1'b0; timed_out = 1'b1; return; end
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        raddr = bus.mem_raddr;
        while (!bus.resp_valid && lat < 20) begin
            if (bus.mem_we) begin we_cnt++; wr_addr = bus.mem_addr; wr_data = bus.mem_wdata; end
            @(negedge clk);
            lat++;
        end
        if (!bus.resp_valid) begin timed_out = 1'b1; return; end
        if (bus.mem_we) we_cnt++;
        rdata = bus.resp_rdata; err = bus.resp_err; rdy_in_resp = bus.req_ready;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        idle_after = bus.req_ready && !bus.resp_valid;
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++; if (bus.req_ready  !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", bus.req_ready); end
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid); end
        total++; if (bus.resp_err   !== 1'b0) begin bad++; $display("FAIL rst_resp_err got=%b exp=0", bus.resp_err); end
        total++; if (bus.mem_we     !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
        total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_resp_rdata got=%h exp=0", bus.resp_rdata); end
        total++; if (bus.mem_addr   !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_addr); end
        total++; if (bus.mem_wdata  !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h exp=0", bus.mem_wdata); end
        total++; if (bus.mem_raddr  !== 32'h0) begin bad++; $display("FAIL rst_mem_raddr got=%h exp=0", bus.mem_raddr); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_directed;
        int lat, wec;
        logic [31:0] wa, wd, ra, rd;
        logic er, rr, ia, to;
        // word store 0xABCD1234 @0x100
        run_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hABCD1234, lat, wec, wa, wd, ra, rd, er, rr, ia, to);
        ref_store(2'd2, 32'h100, 32'hABCD1234);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL sw_timeout got=%b exp=0", to); end
        total++; if (lat != 2) begin bad++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        total++; if (wec != 1) begin bad++; $display("FAIL sw_we_count got=%0d exp=1", wec); end
        total++; if (wa !== 32'h100) begin bad++; $display("FAIL sw_mem_addr got=%h exp=100", wa); end
        total++; if (wd !== 32'hABCD1234) begin bad++; $display("FAIL sw_mem_wdata got=%h exp=abcd1234", wd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL sw_err got=%b exp=0", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL sw_rdata got=%h exp=0", rd); end
        // word load @0x100
        run_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, wec, wa, wd, ra, rd, er, rr, ia, to);
        total++; if (ra !== 32'h100) begin bad++; $display("FAIL lw_raddr got=%h exp=100", ra); end
        total++; if (lat != 3) begin bad++; $display("FAIL lw_latency got=%0d exp=3", lat); end
        total++; if (rd !== 32'hABCD1234) begin bad++; $display("FAIL lw_rdata got=%h exp=abcd1234", rd); end
        // byte store 0x5A @0x101
        run_req(1'b1, 2'd0, 1'b0, 32'h101, 32'hFFFF_FF5A, lat, wec, wa, wd, ra, rd, er, rr, ia, to);
        ref_store(2'd0, 32'h101, 32'h5A);
        total++; if (lat != 4) begin bad++; $display("FAIL sb_latency got=%0d exp=4", lat); end
        total++; if (wec != 1) begin bad++; $display("FAIL sb_we_count got=%0d exp=1", wec); end
        total++; if (wd !== 32'hABCD5A34) begin bad++; $display("FAIL sb_mem_wdata got=%h exp=abcd5a34", wd); end
        total++; if (ra !== 32'h100) begin bad++; $display("FAIL sb_raddr got=%h exp=100", ra); end
        // sub-word loads
        run_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, lat, wec, wa, wd, ra, rd, er, rr, ia, to);
        total++; if (rd !== 32'hFFFFFFAB) begin bad++; $display("FAIL lb_rdata got=%h exp=ffffffab", rd); end
        run_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, lat, wec, wa, wd, ra, rd, er, rr, ia, to);
        total++; if (rd !== 32'h000000AB) begin bad++; $display("FAIL lbu_rdata got=%h exp=000000ab", rd); end
        run_req(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, lat, wec, wa, wd, ra, rd, er, rr, ia, to);
        total++; if (rd !== 32'hFFFFABCD) begin bad++; $display("FAIL lh_rdata got=%h exp=ffffabcd", rd); end
        // misaligned requests
        run_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, lat, wec, wa, wd, ra, rd, er, rr, ia, to);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL lw_mis_err got=%b exp=1", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL lw_mis_rdata got=%h exp=0", rd); end
        total++; if (lat != 1) begin bad++; $display("FAIL lw_mis_latency got=%0d exp=1", lat); end
        run_req(1'b1, 2'd1, 1'b0, 32'h101, 32'h1234, lat, wec, wa, wd, ra, rd, er, rr, ia, to);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL sh_mis_err got=%b exp=1", er); end
        total++; if (wec != 0) begin bad++; $display("FAIL sh_mis_we_count got=%0d exp=0", wec); end
        total++; if (lat != 1) begin bad++; $display("FAIL sh_mis_latency got=%0d exp=1", lat); end
    endtask

    task automatic test_stall;
        int n;
        logic [31:0] exp;
        exp = ref_load(2'd2, 1'b0, 32'h100);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h100; bus.req_wdata = '0;
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 20) begin @(negedge clk); n++; end
        total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL stall_resp_timeout got=%b exp=1", bus.resp_valid); end
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b exp=1", bus.resp_valid); end
            total++; if (bus.resp_rdata !== exp) begin bad++; $display("FAIL stall_rdata got=%h exp=%h", bus.resp_rdata, exp); end
            total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL stall_err got=%b exp=0", bus.resp_err); end
            total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL stall_req_ready got=%b exp=0", bus.req_ready); end
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        #1;
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL resp_consume_ready got=%b exp=0", bus.req_ready); end
        @(negedge clk);
        bus.resp_ready = 1'b0;
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL stall_release_valid got=%b exp=0", bus.resp_valid); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_reset_abort;
        int n, w0, we_seen, lat, wec;
        logic [31:0] wa, wd, ra, rd, exp;
        logic er, rr, ia, to;
        exp = ref_load(2'd2, 1'b0, 32'h100);
        w0 = wr_count;
        we_seen = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h100; bus.req_wdata = 32'hC3;
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (bus.mem_we) we_seen++;
        @(negedge clk);
        if (bus.mem_we) we_seen++;
        rst = 1'b1;
        #1;
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL abort_rst_valid got=%b exp=0", bus.resp_valid); end
        total++; if (bus.mem_raddr !== 32'h0) begin bad++; $display("FAIL abort_rst_raddr got=%h exp=0", bus.mem_raddr); end
        for (int i = 0; i < 2; i++) begin @(negedge clk); if (bus.mem_we) we_seen++; end
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", bus.req_ready); end
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL abort_stale_valid got=%b exp=0", bus.resp_valid); end
        total++; if (we_seen != 0) begin bad++; $display("FAIL abort_we_seen got=%0d exp=0", we_seen); end
        total++; if (wr_count != w0) begin bad++; $display("FAIL abort_writes got=%0d exp=%0d", wr_count - w0, 0); end
        run_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, wec, wa, wd, ra, rd, er, rr, ia, to);
        total++; if (rd !== exp) begin bad++; $display("FAIL abort_reload got=%h exp=%h", rd, exp); end
    endtask

    task automatic test_random;
        int lat, wec, exp_lat;
        logic [31:0] wa, wd, ra, rd, addr, wdata, exp_rd, exp_wd, exp_wa;
        logic er, rr, ia, to, we, uns, exp_err;
        logic [1:0] size;
        for (int t = 0; t < 60; t++) begin
            we = 1'($urandom % 2);
            size = 2'($urandom % 4);
            uns = 1'($urandom % 2);
            addr = (($urandom % 2) != 0 ? 32'hFFFF_FF00 : 32'h100) + $urandom_range(0, 15);
            wdata = $urandom;
            exp_wa = addr & 32'hFFFF_FFFC;
            exp_err = ref_is_err(size, addr);
            exp_rd = (exp_err || we) ? 32'h0 : ref_load(size, uns, addr);
            exp_lat = exp_err ? 1 : (we ? (size == 2'd2 ? 2 : 4) : 3);
            exp_wd = '0;
            if (we && !exp_err) begin
                ref_store(size, addr, wdata);
                exp_wd = ref_load(2'd2, 1'b0, exp_wa);
            end
            run_req(we, size, uns, addr, wdata, lat, wec, wa, wd, ra, rd, er, rr, ia, to);
            total++; if (to !== 1'b0) begin bad++; $display("FAIL rnd_timeout t=%0d got=%b exp=0", t, to); continue; end
            total++; if (er !== exp_err) begin bad++; $display("FAIL rnd_err t=%0d got=%b exp=%b", t, er, exp_err); end
            total++; if (rd !== exp_rd) begin bad++; $display("FAIL rnd_rdata t=%0d got=%h exp=%h", t, rd, exp_rd); end
            total++; if (lat != exp_lat) begin bad++; $display("FAIL rnd_latency t=%0d got=%0d exp=%0d", t, lat, exp_lat); end
            total++; if (ra !== exp_wa) begin bad++; $display("FAIL rnd_raddr t=%0d got=%h exp=%h", t, ra, exp_wa); end
            total++; if (wec != ((we && !exp_err) ? 1 : 0)) begin bad++; $display("FAIL rnd_we_count t=%0d got=%0d", t, wec); end
            if (we && !exp_err) begin
                total++; if (wa !== exp_wa) begin bad++; $display("FAIL rnd_mem_addr t=%0d got=%h exp=%h", t, wa, exp_wa); end
                total++; if (wd !== exp_wd) begin bad++; $display("FAIL rnd_mem_wdata t=%0d got=%h exp=%h", t, wd, exp_wd); end
            end
            total++; if (rr !== 1'b0) begin bad++; $display("FAIL rnd_ready_in_resp t=%0d got=%b exp=0", t, rr); end
            total++; if (ia !== 1'b1) begin bad++; $display("FAIL rnd_back_to_idle t=%0d got=%b exp=1", t, ia); end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = '0; bus.req_unsigned = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
        test_reset();
        test_directed();
        test_stall();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
